multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle control sequencer for the MIPS core: a Moore-style FSM that walks each instruction through fetch, decode, execute, memory and writeback over several clocks. It drives the shared single-ported memory, IR, PC, register file and ALU muxes, and stalls on a memory ready handshake. It supersedes the single-cycle opcode decode for the multicycle datapath and also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- mem_read / mem_write  out  1  memory strobes
- iord  out  1  0 = address from PC, 1 = from ALUOut
- ir_write  out  1  load IR
- pc_en  out  1  PC load = pc_write | (branch & zero)
- branch  out  1  conditional PC load
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_dst / mem_to_reg / reg_write  out  1  register-file controls
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state, for debug
- retired  out  CNT_W  retired-instruction count

## Operation
States with encodings; all unlisted outputs are 0:
- FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_en equal mem_ready. Stay while !mem_ready; on mem_ready, go to DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by op:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 -> EXEC
  - 001000 -> ADDIEX
  - 000100 -> BEQ
  - 000010 -> JUMP (with JUMP_EN only)
  - otherwise -> FETCH, with illegal_op=1 for that cycle
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD (3): mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR (5): mem_write=1, iord=1. Wait for mem_ready, then -> FETCH.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB (7): reg_write=1, reg_dst=1 -> FETCH.
- BEQ (8): alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01 -> FETCH.
- ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB (10): reg_write=1, reg_dst=0 -> FETCH.
- JUMP (11): pc_src=10, pc_en=1 -> FETCH.

Control rules:
- Encodings 12–15 are unreachable; if entered, the FSM goes to FETCH.
- retired increments by 1 on the clock edge leaving MEMWB, MEMWR (when mem_ready), ALUWB, BEQ, ADDIWB or JUMP.
- retired wraps modulo 2^CNT_W.
- Illegal opcodes do not increment retired.

## Timing
- Reset asserted: state=FETCH and retired=0 immediately, asynchronously. Outputs take FETCH values, with ir_write=pc_en=0 until mem_ready.
- Reset deasserted: first transition on the next rising clk.
- Reset mid-instruction abandons it; no partial writeback and no counter update.
- Latency with mem_ready tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each memory wait cycle adds exactly 1 cycle.
- Memory requests are held stable (mem_read/mem_write, iord) until the cycle mem_ready=1. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- pc_en in BEQ is combinational from zero in the same cycle.
- mem_read and mem_write are never both 1.
- reg_write is never 1 in the same cycle as mem_write.

## Configuration
- JUMP_EN defined: opcode 000010 decodes to the JUMP state (11), and pc_src=10 is reachable.
- JUMP_EN undefined: opcode 000010 is illegal (illegal_op pulse, back to FETCH), state 11 is absent, and pc_src is never 10.

## Test plan
- Reset then mem_ready=1, op=000000: states 0,1,6,7,0; reg_write=1 with reg_dst=1 in state 7; retired=1.
- lw (op=100011) with mem_ready low for 2 cycles in MEMRD: MEMRD lasts 3 cycles with iord=1 and mem_read held; MEMWB has mem_to_reg=1; total 7 cycles.
- beq with zero=1: pc_en=1 and pc_src=01 in BEQ; with zero=0: pc_en=0; both retire.
- op=111111: illegal_op pulses 1 cycle in DECODE, next state FETCH, retired unchanged.
- Drive reset_n low mid-MEMWR: state=0 immediately, mem_write=0, retired=0; normal fetch after release.
- op=000010: with JUMP_EN, state 11 and pc_en=1; without JUMP_EN, illegal_op=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control sequencer: Moore FSM from fetch to writeback, with memory stall and retired-instruction counter.
// Optional feature macro: JUMP_EN (enables the j instruction / JUMP state).
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic             branch,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
`ifdef JUMP_EN
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`else
    S_ADDIWB = 4'd10
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             pc_write;
  logic             retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BEQ;
`ifdef JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      // Unused encodings recover to FETCH with all controls idle.
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  assign pc_en   = pc_write | (branch & zero);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: per-cycle vectors of inputs vs expected state/controls/count, plus reset-abort sequence.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  op = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, iord, ir_write, pc_en, branch;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0]  state, state2;
  logic [31:0] retired;
  logic [1:0]  retired2;
  logic        mr2, mw2, io2, irw2, pce2, br2, asa2, rd2, m2r2, rw2, ill2;
  logic [1:0]  pcs2, asb2, aop2;
  logic [16:0] ctrl;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  // Narrow counter copy, used to observe wrap-around.
  multicycle_controller #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mr2), .mem_write(mw2), .iord(io2), .ir_write(irw2),
    .pc_en(pce2), .branch(br2), .pc_src(pcs2), .alu_src_a(asa2),
    .alu_src_b(asb2), .alu_op(aop2), .reg_dst(rd2), .mem_to_reg(m2r2),
    .reg_write(rw2), .illegal_op(ill2), .state(state2), .retired(retired2)
  );

  assign ctrl = {mem_read, mem_write, iord, ir_write, pc_en, branch, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};

  // Field order: mr mw iord irw pcen br pcsrc asa asb aop rd m2r rw ill
  localparam logic [16:0] C_FETCH_R = 17'b1_0_0_1_1_0_00_0_01_00_0_0_0_0;
  localparam logic [16:0] C_FETCH_W = 17'b1_0_0_0_0_0_00_0_01_00_0_0_0_0;
  localparam logic [16:0] C_DEC     = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_0;
  localparam logic [16:0] C_DEC_ILL = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_1;
  localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [16:0] C_MEMRD   = 17'b1_0_1_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_00_0_00_00_0_1_1_0;
  localparam logic [16:0] C_MEMWR   = 17'b0_1_1_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_00_1_00_10_0_0_0_0;
  localparam logic [16:0] C_ALUWB   = 17'b0_0_0_0_0_0_00_0_00_00_1_0_1_0;
  localparam logic [16:0] C_BEQ_T   = 17'b0_0_0_0_1_1_01_1_00_01_0_0_0_0;
  localparam logic [16:0] C_BEQ_N   = 17'b0_0_0_0_0_1_01_1_00_01_0_0_0_0;
  localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_00_0_00_00_0_0_1_0;
`ifdef JUMP_EN
  localparam logic [16:0] C_JUMP    = 17'b0_0_0_0_1_0_10_0_00_00_0_0_0_0;
`endif

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        mrdy;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic void add(input logic [5:0] o, input logic z, input logic m,
                              input logic [3:0] s, input logic [16:0] c, input logic [31:0] r);
    vec_t v;
    v.op = o; v.zero = z; v.mrdy = m; v.st = s; v.ctrl = c; v.ret = r;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s [%0d]: got %h want %h", name, idx, got, want);
    else
      n_pass++;
  endtask

  initial begin
    // R-type
    add(6'o00, 0, 1, 0, C_FETCH_R, 0);
    add(6'o00, 0, 0, 1, C_DEC,     0);
    add(6'o00, 0, 1, 6, C_EXEC,    0);
    add(6'o00, 0, 0, 7, C_ALUWB,   0);
    // lw: one fetch stall, then two MEMRD wait cycles
    add(6'b100011, 0, 0, 0, C_FETCH_W, 1);
    add(6'b100011, 0, 1, 0, C_FETCH_R, 1);
    add(6'b100011, 0, 1, 1, C_DEC,     1);
    add(6'b100011, 0, 1, 2, C_MEMADR,  1);
    add(6'b100011, 0, 0, 3, C_MEMRD,   1);
    add(6'b100011, 0, 0, 3, C_MEMRD,   1);
    add(6'b100011, 0, 1, 3, C_MEMRD,   1);
    add(6'b100011, 0, 0, 4, C_MEMWB,   1);
    // sw
    add(6'b101011, 0, 1, 0, C_FETCH_R, 2);
    add(6'b101011, 0, 1, 1, C_DEC,     2);
    add(6'b101011, 0, 0, 2, C_MEMADR,  2);
    add(6'b101011, 0, 1, 5, C_MEMWR,   2);
    // addi
    add(6'b001000, 0, 1, 0,  C_FETCH_R, 3);
    add(6'b001000, 0, 1, 1,  C_DEC,     3);
    add(6'b001000, 0, 1, 9,  C_MEMADR,  3);
    add(6'b001000, 0, 1, 10, C_ADDIWB,  3);
    // beq taken / not taken
    add(6'b000100, 0, 1, 0, C_FETCH_R, 4);
    add(6'b000100, 1, 1, 1, C_DEC,     4);
    add(6'b000100, 1, 1, 8, C_BEQ_T,   4);
    add(6'b000100, 1, 1, 0, C_FETCH_R, 5);
    add(6'b000100, 0, 1, 1, C_DEC,     5);
    add(6'b000100, 0, 1, 8, C_BEQ_N,   5);
    // illegal opcode
    add(6'b111111, 0, 1, 0, C_FETCH_R, 6);
    add(6'b111111, 0, 1, 1, C_DEC_ILL, 6);
    // j
    add(6'b000010, 0, 0, 0, C_FETCH_W, 6);
    add(6'b000010, 0, 1, 0, C_FETCH_R, 6);
`ifdef JUMP_EN
    add(6'b000010, 0, 1, 1,  C_DEC,     6);
    add(6'b000010, 0, 1, 11, C_JUMP,    6);
    add(6'b000000, 0, 1, 0,  C_FETCH_R, 7);
`else
    add(6'b000010, 0, 1, 1, C_DEC_ILL, 6);
    add(6'b000000, 0, 1, 0, C_FETCH_R, 6);
`endif

    // Reset state
    #12;
    check("rst_state", -1, 32'(state), 32'd0);
    check("rst_ctrl", -1, 32'(ctrl), 32'(C_FETCH_W));
    check("rst_retired", -1, retired, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].mrdy;
      @(negedge clk);
      check("state", i, 32'(state), 32'(vecs[i].st));
      check("ctrl", i, 32'(ctrl), 32'(vecs[i].ctrl));
      check("retired", i, retired, vecs[i].ret);
      check("retired_w2", i, 32'(retired2), 32'(vecs[i].ret[1:0]));
      @(posedge clk); #1;
    end

    // Now in DECODE: drive a sw and abort it with reset while stalled in MEMWR
    op = 6'b101011; mem_ready = 1'b1;
    @(negedge clk);
    check("abort_dec", 0, 32'(state), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort_adr", 0, 32'(state), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_memwr", 0, 32'(state), 32'd5);
    check("abort_mw_on", 0, 32'(mem_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_state", 0, 32'(state), 32'd0);
    check("abort_mw_off", 0, 32'(mem_write), 32'd0);
    check("abort_ctrl", 0, 32'(ctrl), 32'(C_FETCH_W));
    check("abort_retired", 0, retired, 32'd0);
    check("abort_retired_w2", 0, 32'(retired2), 32'd0);
    @(posedge clk); #1;
    check("abort_hold", 0, 32'(state), 32'd0);
    reset_n = 1'b1; op = 6'b000000; mem_ready = 1'b1;
    @(negedge clk);
    check("post_fetch", 0, 32'(ctrl), 32'(C_FETCH_R));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_decode", 0, 32'(state), 32'd1);
    check("post_retired", 0, retired, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
